// File: rtl/branch_predictor_if.sv
// Fetch-lookup, ID-update and statistics bundle shared by
// the branch predictor and the pipeline.
interface branch_predictor_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 16
);
  logic [ADDR_W-1:0] if_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [ADDR_W-1:0] upd_pred_target;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_taken,
    output upd_target, upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc,
    input  stat_branches, stat_mispredicts
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_taken,
    input  upd_target, upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc,
    output stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters
// and saturating branch/mispredict statistics.
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int STAT_W  = 16
) (
  input logic clk,
  input logic reset,
  branch_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [ADDR_W-1:0] tgt_q   [ENTRIES];
  logic [1:0]        ctr_q   [ENTRIES];
  logic [STAT_W-1:0] branches_q;
  logic [STAT_W-1:0] mispred_q;

  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [TAG_W-1:0]  rd_tag;
  logic [TAG_W-1:0]  wr_tag;
  logic              rd_hit;
  logic              wr_hit;
  logic              mispred;
  logic [ADDR_W-1:0] rd_seq;
  logic [ADDR_W-1:0] wr_seq;

  assign rd_idx = bus.if_pc[IDX_W+1:2];
  assign rd_tag = bus.if_pc[ADDR_W-1:IDX_W+2];
  assign wr_idx = bus.upd_pc[IDX_W+1:2];
  assign wr_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];
  assign rd_seq = bus.if_pc + ADDR_W'(4);
  assign wr_seq = bus.upd_pc + ADDR_W'(4);

  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  assign bus.pred_taken  = rd_hit & ctr_q[rd_idx][1];
  assign bus.pred_target = bus.pred_taken ? tgt_q[rd_idx] : rd_seq;

  assign mispred = bus.upd_valid &
    ((bus.upd_taken != bus.upd_pred_taken) |
     (bus.upd_taken & (bus.upd_target != bus.upd_pred_target)));

  assign bus.mispredict  = mispred;
  assign bus.redirect_pc = !bus.upd_valid ? '0 :
                           bus.upd_taken ? bus.upd_target : wr_seq;

  assign bus.stat_branches    = branches_q;
  assign bus.stat_mispredicts = mispred_q;

  // Tags and targets are left stale on reset; valid gates them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
      branches_q <= '0;
      mispred_q  <= '0;
    end else begin
      if (bus.upd_valid) begin
        unique case (1'b1)
          wr_hit && bus.upd_taken: begin
            if (ctr_q[wr_idx] != 2'b11)
              ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'b01;
            tgt_q[wr_idx] <= bus.upd_target;
          end
          wr_hit && !bus.upd_taken: begin
            if (ctr_q[wr_idx] != 2'b00)
              ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'b01;
          end
          !wr_hit && bus.upd_taken: begin
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= wr_tag;
            tgt_q[wr_idx]   <= bus.upd_target;
            ctr_q[wr_idx]   <= 2'b10;
          end
          default: ;
        endcase
      end
      if (bus.upd_valid && branches_q != '1)
        branches_q <= branches_q + STAT_W'(1);
      if (mispred && mispred_q != '1)
        mispred_q <= mispred_q + STAT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus random checks of branch_predictor against a
// table model built from plain arithmetic on PCs.
module tb_branch_predictor;
  localparam int STAT_MAX = 15;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  branch_predictor_if #(.ADDR_W(32), .STAT_W(4)) bus ();

  branch_predictor #(
    .ADDR_W(32), .ENTRIES(16), .STAT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit          m_v   [16];
  int unsigned m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];
  int          m_br;
  int          m_mp;

  function automatic int slot(logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic int unsigned tagof(logic [31:0] pc);
    return pc / 64;
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_v[slot(pc)] && m_tag[slot(pc)] == tagof(pc);
  endfunction

  function automatic bit m_ptaken(logic [31:0] pc);
    return m_hit(pc) && m_ctr[slot(pc)] >= 2;
  endfunction

  function automatic logic [31:0] m_ptgt(logic [31:0] pc);
    return m_ptaken(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i]   = 1'b0;
      m_ctr[i] = 1;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check combinational outputs, clock, train model.
  task automatic step(
    input logic [31:0] ipc,
    input bit          uv,
    input logic [31:0] upc,
    input bit          ut,
    input logic [31:0] utgt,
    input bit          upt,
    input logic [31:0] uptgt,
    input bit          rst
  );
    bit          exp_mp;
    logic [31:0] exp_rd;
    int          s;
    reset               = rst;
    bus.if_pc           = ipc;
    bus.upd_valid       = uv;
    bus.upd_pc          = upc;
    bus.upd_taken       = ut;
    bus.upd_target      = utgt;
    bus.upd_pred_taken  = upt;
    bus.upd_pred_target = uptgt;
    #1;
    exp_mp = uv && ((ut != upt) || (ut && utgt != uptgt));
    exp_rd = !uv ? 32'd0 : (ut ? utgt : upc + 32'd4);
    chk("pred_taken", 32'(bus.pred_taken), 32'(m_ptaken(ipc)));
    chk("pred_target", bus.pred_target, m_ptgt(ipc));
    chk("mispredict", 32'(bus.mispredict), 32'(exp_mp));
    chk("redirect_pc", bus.redirect_pc, exp_rd);
    chk("stat_branches", 32'(bus.stat_branches), 32'(m_br));
    chk("stat_mispredicts", 32'(bus.stat_mispredicts), 32'(m_mp));
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else begin
      s = slot(upc);
      if (uv) begin
        if (m_hit(upc)) begin
          if (ut) begin
            m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
            m_tgt[s] = utgt;
          end else begin
            m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
          end
        end else if (ut) begin
          m_v[s]   = 1'b1;
          m_tag[s] = tagof(upc);
          m_tgt[s] = utgt;
          m_ctr[s] = 2;
        end
        m_br = (m_br + 1 > STAT_MAX) ? STAT_MAX : m_br + 1;
      end
      if (exp_mp)
        m_mp = (m_mp + 1 > STAT_MAX) ? STAT_MAX : m_mp + 1;
    end
    #1;
  endtask

  task automatic peek(
    string tag, input logic [31:0] ipc,
    input bit et, input logic [31:0] etgt
  );
    reset         = 1'b0;
    bus.if_pc     = ipc;
    bus.upd_valid = 1'b0;
    #1;
    chk({tag, ".taken"}, 32'(bus.pred_taken), 32'(et));
    chk({tag, ".target"}, bus.pred_target, etgt);
  endtask

  localparam logic [31:0] PA = 32'h0040_0010;
  localparam logic [31:0] PB = 32'h0040_0050;
  localparam logic [31:0] PC = 32'h0040_0020;
  localparam logic [31:0] PD = 32'h0040_0030;
  localparam logic [31:0] TA = 32'h0040_0100;
  localparam logic [31:0] TB = 32'h0040_0200;

  initial begin
    logic [31:0] rp;
    logic [31:0] ri;
    bit          rt;
    bit          rpt;
    logic [31:0] rtg;
    logic [31:0] rptg;
    checks = 0;
    errors = 0;
    m_reset();
    reset               = 1'b1;
    bus.if_pc           = '0;
    bus.upd_valid       = 1'b0;
    bus.upd_pc          = '0;
    bus.upd_taken       = 1'b0;
    bus.upd_target      = '0;
    bus.upd_pred_taken  = 1'b0;
    bus.upd_pred_target = '0;
    @(posedge clk);
    #1;

    peek("reset_lookup", PA, 1'b0, 32'h0040_0014);
    chk("reset_branches", 32'(bus.stat_branches), 32'd0);

    step(PA, 1, PA, 1, TA, 0, PA + 4, 0);
    peek("alloc", PA, 1'b1, TA);
    chk("alloc_branches", 32'(bus.stat_branches), 32'd1);
    chk("alloc_mispred", 32'(bus.stat_mispredicts), 32'd1);

    step(PA, 1, PA, 1, TA, 1, TA, 0);
    step(PA, 1, PA, 1, TA, 1, TA, 0);
    step(PA, 1, PA, 0, TA, 1, TA, 0);
    peek("hyst_nt1", PA, 1'b1, TA);
    step(PA, 1, PA, 0, TA, 1, TA, 0);
    peek("hyst_nt2", PA, 1'b0, PA + 4);
    step(PA, 1, PA, 0, TA, 0, PA + 4, 0);
    step(PA, 1, PA, 0, TA, 0, PA + 4, 0);
    step(PA, 1, PA, 1, TA, 0, PA + 4, 0);
    peek("hyst_floor", PA, 1'b0, PA + 4);
    step(PA, 1, PA, 1, TA, 0, PA + 4, 0);
    peek("hyst_retrain", PA, 1'b1, TA);

    peek("alias_lookup", PB, 1'b0, PB + 4);
    step(PB, 1, PB, 1, TB, 0, PB + 4, 0);
    peek("alias_new", PB, 1'b1, TB);
    peek("alias_old", PA, 1'b0, PA + 4);

    step(PC, 1, PC, 1, TA, 0, PC + 4, 0);
    peek("same_cycle_after", PC, 1'b1, TA);

    step(PD, 1, PD, 1, TB, 0, PD + 4, 1);
    peek("rst_prio", PD, 1'b0, PD + 4);
    chk("rst_prio_branches", 32'(bus.stat_branches), 32'd0);
    chk("rst_prio_mispred", 32'(bus.stat_mispredicts), 32'd0);

    for (int i = 0; i < 20; i++)
      step(PA, 1, PA + 32'(i * 4), 1, TA, 0, PA, 0);
    chk("sat_branches", 32'(bus.stat_branches), 32'd15);
    chk("sat_mispred", 32'(bus.stat_mispredicts), 32'd15);

    for (int i = 0; i < 400; i++) begin
      rp = 32'h0040_0000 + 32'($urandom_range(0, 2) * 64)
         + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      ri = ($urandom_range(0, 1) == 1) ? rp
         : 32'h0040_0000 + 32'($urandom_range(0, 191) * 4);
      rt  = 1'($urandom_range(0, 1));
      rtg = 32'h0040_0000 + 32'($urandom_range(0, 7) * 16);
      if ($urandom_range(0, 2) != 0) begin
        rpt  = m_ptaken(rp);
        rptg = m_ptgt(rp);
      end else begin
        rpt  = 1'($urandom_range(0, 1));
        rptg = 32'h0040_0000 + 32'($urandom_range(0, 7) * 16);
      end
      step(ri, 1'($urandom_range(0, 3) != 0), rp, rt, rtg, rpt, rptg,
           $urandom_range(0, 59) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with 2-bit saturating direction counters. It lets the pipelined processor's fetch stage predict taken branches and jumps, which the current design cannot do: today the design always fetches PC+4 and flushes IF/ID when ID resolves a branch. Fetch queries the block combinationally with the current PC. ID reports each resolved branch, and the block updates its table and raises a mispredict/redirect. The block also keeps saturating performance counters.

## Interface
Parameters:
- ADDR_W, 32, PC/target width in bits
- ENTRIES, 16, table entries; power of two, ≥2; IDX_W = log2(ENTRIES)
- STAT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears table state and counters
- if_pc  in  ADDR_W  PC currently being fetched
- pred_taken  out  1  prediction for if_pc: 1 = taken
- pred_target  out  ADDR_W  next fetch PC predicted for if_pc
- upd_valid  in  1  ID resolved a branch/jump this cycle
- upd_pc  in  ADDR_W  PC of the resolved instruction
- upd_taken  in  1  actual direction
- upd_target  in  ADDR_W  actual target (meaningful when upd_taken=1)
- upd_pred_taken  in  1  prediction that was made for upd_pc, carried down the pipe
- upd_pred_target  in  ADDR_W  predicted next PC carried down the pipe
- mispredict  out  1  fetch must flush and redirect
- redirect_pc  out  ADDR_W  correct next PC when mispredict=1
- stat_branches  out  STAT_W  resolved-branch count
- stat_mispredicts  out  STAT_W  mispredict count

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] ignored.
- Each entry holds valid, tag, target[ADDR_W], ctr[1:0].
- Lookup (combinational):
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = entry target if pred_taken, else if_pc+4, computed modulo 2^ADDR_W.
- Update, on the edge when upd_valid=1:
  - Hit, upd_taken=1: ctr saturating-increments (max 2'b11); target ← upd_target.
  - Hit, upd_taken=0: ctr saturating-decrements (min 2'b00); target unchanged.
  - Miss, upd_taken=1: allocate/replace. valid=1, tag, target=upd_target, ctr=2'b10.
  - Miss, upd_taken=0: no change.
- Mispredict (combinational, gated by upd_valid):
  - mispredict = upd_valid & ((upd_taken ≠ upd_pred_taken) | (upd_taken & upd_target ≠ upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - redirect_pc is driven whenever upd_valid=1, and is 0 when upd_valid=0.
- Performance counters:
  - stat_branches increments on each upd_valid.
  - stat_mispredicts increments on each mispredict.
  - Both saturate at 2^STAT_W−1 and never wrap.

## Timing
- Lookup latency is 0 cycles, from if_pc to pred_*.
- Update is visible to lookups from the cycle after the upd_valid edge.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update contents; there is no bypass.
- mispredict and redirect_pc are valid in the same cycle as upd_valid.
- Counters reflect an event one cycle after it.
- Reset, sampled at the rising edge:
  - all valid=0, all ctr=2'b01, both counters=0.
  - Tags and targets need not be cleared.
- After reset, outputs are pred_taken=0 and pred_target=if_pc+4. mispredict and redirect_pc follow the upd_* inputs combinationally.
- reset=1 with upd_valid=1: reset wins. No table write and no counter increment. mispredict still reflects its combinational inputs.
- Reset mid-stream discards all training; the first lookup after reset is not-taken.

## Test plan
- Reset then lookup: reset 1 cycle; if_pc=0x0040_0010 -> pred_taken=0, pred_target=0x0040_0014, stat_branches=0.
- Allocate and predict:
  - Stimulus: upd_valid=1, upd_pc=0x0040_0010, taken, target=0x0040_0100, pred_taken=0.
  - Same cycle: mispredict=1, redirect_pc=0x0040_0100.
  - Next cycle, if_pc=0x0040_0010: pred_taken=1, pred_target=0x0040_0100. stat_branches=1, stat_mispredicts=1.
- Counter hysteresis:
  - Train the same PC taken three times (ctr=11).
  - First not-taken update: pred still 1 (ctr=10).
  - Second not-taken update: pred 0 (ctr=01), pred_target=PC+4.
  - Further not-taken updates: ctr held at 00.
- Alias/tag:
  - Allocate 0x0040_0010.
  - Lookup 0x0040_0050 (same index, ENTRIES=16, different tag) -> pred_taken=0.
  - Taken update at 0x0040_0050 replaces the entry; 0x0040_0010 then misses.
- Same-cycle read/update, and saturation:
  - Stimulus: if_pc=upd_pc=0x0040_0020 with a first taken update.
  - That cycle: pred_taken=0. Next cycle: pred_taken=1.
  - With STAT_W=4, 20 mispredicting updates -> stat_mispredicts=15, stat_branches=15.
- Reset priority: reset=1 with a taken upd_valid -> next cycle lookup of that PC not-taken, counters 0.
